rps_match_ctrl: RTL
===================

// Module: rps_match_ctrl
// PURPOSE
//  Referee/sequencer for a best-of match between two Rock-Paper-Scissors players.
//  Collects one move per player per round over independent valid/ready handshakes and
//  judges the latched pair with a combinational judge. Keeps score and round count.
//  Declares the match winner once either player reaches WIN_TARGET round wins.
// PARAMETERS
//  WIN_TARGET  3  round wins needed to take the match (>=1)
//  SCORE_W     3  score counter width; elaboration assert $clog2(WIN_TARGET+1) <= SCORE_W
//  ROUND_W     8  round counter width
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        asynchronous, active-high reset
//  start         in   1        begin new match (accepted only in IDLE or DONE)
//  a_valid       in   1        player A move offered
//  a_move        in   3        player A move (one-hot: 001 rock, 010 paper, 100 scissors)
//  a_ready       out  1        ctrl will accept A move this cycle
//  b_valid       in   1        player B move offered
//  b_move        in   3        player B move, same encoding
//  b_ready       out  1        ctrl will accept B move this cycle
//  round_done    out  1        one-cycle pulse: round_result valid
//  round_result  out  2        00 tie, 01 A wins, 10 B wins, 11 invalid move(s)
//  score_a       out  SCORE_W  rounds won by A this match
//  score_b       out  SCORE_W  rounds won by B this match
//  round_cnt     out  ROUND_W  rounds judged this match (incl. tie/invalid), saturates at all-ones
//  busy          out  1        match in progress (COLLECT/JUDGE/REPORT)
//  match_done    out  1        level, high in DONE
//  match_winner  out  1        0 = A, 1 = B; meaningful only while match_done
// BEHAVIOUR
//  Reset (async assert, all regs): state IDLE, all outputs 0, latched moves/flags cleared.
//  States: IDLE, COLLECT, JUDGE, REPORT, DONE.
//  IDLE: a/b_ready=0. start -> clear scores/round_cnt, go COLLECT.
//  COLLECT: a_ready = !a_got, b_ready = !b_got. Capture move and set flag on valid&&ready.
//   - Moves may arrive in either order or the same cycle; once captured, ready stays low.
//   - Both flags set (after edge) -> JUDGE. Valid while ready=0 is ignored.
//  JUDGE (1 cycle): judge latched pair. valid = both moves one-hot. Paper>rock,
//   rock>scissors, scissors>paper; equal moves = tie.
//   - At exit edge: register round_result, increment winner score (tie/invalid: none).
//   - round_cnt += 1 (saturating); clear flags. Go REPORT.
//  REPORT (1 cycle): round_done=1, round_result/scores show this round.
//   - Either score == WIN_TARGET -> DONE, else -> COLLECT.
//  Latency: second capture edge -> round_done high exactly 2 cycles later.
//  DONE: match_done=1, match_winner held, scores/round_cnt held, ready=0.
//   - start -> clear scores/round_cnt/result, match_done=0, go COLLECT.
//  start outside IDLE/DONE is ignored. round_result holds last value between pulses.
//  busy=1 in COLLECT/JUDGE/REPORT only.
//  Scores never exceed WIN_TARGET (match ends at the edge reaching it); no wrap.
//  rst mid-round: captured moves discarded, no round_done pulse, scores lost.
// STRUCTURE
//  Package rps_pkg:
//   - move_t enum {MV_ROCK=3'b001, MV_PAPER=3'b010, MV_SCISSORS=3'b100}
//   - result_t enum {RES_TIE=2'b00, RES_A=2'b01, RES_B=2'b10, RES_INVALID=2'b11}
//   - state_t enum for the FSM.
//  Sub-module rps_round_judge: purely combinational (move_a, move_b -> result_t);
//   instanced once, fed from latched moves. All sequencing/scoring lives in rps_match_ctrl.
// TESTING (WIN_TARGET=3)
//  1 Reset, start; same cycle A=001, B=100 -> a/b_ready low next cycle.
//    Two cycles after capture: round_done=1, RES_A, score_a=1, round_cnt=1.
//  2 A=010 at cycle 3, B=010 at cycle 7 -> a_ready=0 cycles 4-7, A valid ignored.
//    Then RES_TIE, scores 0/0, round_cnt=1.
//  3 A=3'b011, B=001 -> RES_INVALID, scores unchanged, returns to COLLECT.
//  4 Rounds B,A,B,A,B -> after 5th: score_b=3, score_a=2, match_done=1, match_winner=1.
//    busy=0; further valid never sees ready.
//  5 Both moves captured, assert rst during JUDGE -> all outputs 0 immediately.
//    No round_done, state IDLE.
//  6 start while busy -> no effect. start in DONE -> scores/round_cnt 0, match_done=0.
//    a_ready=b_ready=1 next cycle.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match controller: move and result
// encodings, FSM states and a one-hot move check.
package rps_pkg;

    typedef enum logic [2:0] {
        MV_ROCK     = 3'b001,
        MV_PAPER    = 3'b010,
        MV_SCISSORS = 3'b100
    } move_t;

    typedef enum logic [1:0] {
        RES_TIE     = 2'b00,
        RES_A       = 2'b01,
        RES_B       = 2'b10,
        RES_INVALID = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_JUDGE,
        ST_REPORT,
        ST_DONE
    } state_t;

    function automatic logic is_move(input logic [2:0] m);
        return (m == MV_ROCK) || (m == MV_PAPER) || (m == MV_SCISSORS);
    endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational referee for one round: compares two latched moves and names
// the winner, a tie, or an invalid pairing.
module rps_round_judge
    import rps_pkg::*;
(
    input  logic [2:0] move_a,
    input  logic [2:0] move_b,
    output result_t    result
);

    // Any non-one-hot move voids the round before the usual cyclic ordering is applied.
    always_comb begin
        result = RES_TIE;
        if (!is_move(move_a) || !is_move(move_b)) begin
            result = RES_INVALID;
        end else if (move_a == move_b) begin
            result = RES_TIE;
        end else if ((move_a == MV_PAPER    && move_b == MV_ROCK)  ||
                     (move_a == MV_ROCK     && move_b == MV_SCISSORS) ||
                     (move_a == MV_SCISSORS && move_b == MV_PAPER)) begin
            result = RES_A;
        end else begin
            result = RES_B;
        end
    end

endmodule

// File: rtl/rps_match_ctrl.sv
// Best-of match sequencer: collects one move per player per round, judges the
// pair, keeps score and round count, and declares the match winner.
module rps_match_ctrl
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 3,
    parameter int ROUND_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               a_valid,
    input  logic [2:0]         a_move,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [2:0]         b_move,
    output logic               b_ready,
    output logic               round_done,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               busy,
    output logic               match_done,
    output logic               match_winner
);

    localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);

    if ($clog2(WIN_TARGET + 1) > SCORE_W || WIN_TARGET < 1) begin : g_bad_params
        $error("rps_match_ctrl: WIN_TARGET must be >= 1 and fit in SCORE_W bits");
    end

    state_t     state, state_n;
    logic [2:0] a_mv, b_mv;
    logic       a_got, b_got;
    result_t    res_q, judge_res;

    rps_round_judge u_judge (
        .move_a (a_mv),
        .move_b (b_mv),
        .result (judge_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        round_done = 1'b0;
        busy       = 1'b0;
        match_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_COLLECT;
            end
            ST_COLLECT: begin
                busy    = 1'b1;
                a_ready = !a_got;
                b_ready = !b_got;
                if (a_got && b_got) state_n = ST_JUDGE;
            end
            ST_JUDGE: begin
                busy    = 1'b1;
                state_n = ST_REPORT;
            end
            ST_REPORT: begin
                busy       = 1'b1;
                round_done = 1'b1;
                state_n    = (score_a == WIN_T || score_b == WIN_T) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                match_done = 1'b1;
                if (start) state_n = ST_COLLECT;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Scores are only touched on the JUDGE exit edge, so REPORT always shows the fresh round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mv         <= '0;
            b_mv         <= '0;
            a_got        <= 1'b0;
            b_got        <= 1'b0;
            res_q        <= RES_TIE;
            score_a      <= '0;
            score_b      <= '0;
            round_cnt    <= '0;
            match_winner <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        res_q        <= RES_TIE;
                        score_a      <= '0;
                        score_b      <= '0;
                        round_cnt    <= '0;
                        match_winner <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (a_valid && a_ready) begin
                        a_mv  <= a_move;
                        a_got <= 1'b1;
                    end
                    if (b_valid && b_ready) begin
                        b_mv  <= b_move;
                        b_got <= 1'b1;
                    end
                end
                ST_JUDGE: begin
                    res_q <= judge_res;
                    if (judge_res == RES_A) score_a <= score_a + 1'b1;
                    if (judge_res == RES_B) score_b <= score_b + 1'b1;
                    if (round_cnt != '1) round_cnt <= round_cnt + 1'b1;
                    a_got <= 1'b0;
                    b_got <= 1'b0;
                end
                ST_REPORT: begin
                    if (score_b == WIN_T)      match_winner <= 1'b1;
                    else if (score_a == WIN_T) match_winner <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign round_result = res_q;

endmodule
